// File: rtl/cpu_bus_arbiter.sv
// Merges the CPU instruction and data buses onto one request/ready system bus; optional watchdog.
// Latency: 1 cycle IDLE arbitration, then request/ready pass through combinationally during a grant.
// Backpressure: a master is held (no ready) until the slave pulses ready or the watchdog expires.
// Optional feature: define CPU_BUS_ARBITER_ROUND_ROBIN_EN for round-robin on simultaneous requests.
module cpu_bus_arbiter #(
   parameter int TIMEOUT = 1024
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_ibus_request,
   output logic        o_ibus_ready,
   input  logic [31:0] i_ibus_address,
   output logic [31:0] o_ibus_rdata,
   input  logic        i_dbus_rw,
   input  logic        i_dbus_request,
   output logic        o_dbus_ready,
   input  logic [31:0] i_dbus_address,
   output logic [31:0] o_dbus_rdata,
   input  logic [31:0] i_dbus_wdata,
   output logic        o_bus_rw,
   output logic        o_bus_request,
   input  logic        i_bus_ready,
   output logic [31:0] o_bus_address,
   input  logic [31:0] i_bus_rdata,
   output logic [31:0] o_bus_wdata,
   output logic        o_timeout
);

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

   // A zero TIMEOUT still needs a legal one-bit counter; it simply never matches.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t        state, state_nxt;
   logic [CW-1:0] wd_cnt;
   logic          wd_expired;
   logic          set_timeout;
   logic          pick_d;

   assign wd_expired = (TIMEOUT > 0) && (wd_cnt == CW'(TIMEOUT));

`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
   logic last_d;  // 1 = dbus was the master served most recently

   // On a tie, grant whichever master was not served last.
   always_comb begin
      pick_d = i_dbus_request & (~i_ibus_request | ~last_d);
   end

   // Remember who was served whenever a grant ends (ready, timeout or abort).
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)
         last_d <= 1'b0;
      else if (state != IDLE && state_nxt == IDLE)
         last_d <= (state == GRANT_D);
   end
`else
   // Fixed priority: dbus wins any tie.
   always_comb begin
      pick_d = i_dbus_request;
   end
`endif

   // Next state and all bus outputs; IDLE drives everything to zero.
   always_comb begin
      state_nxt     = state;
      set_timeout   = 1'b0;
      o_bus_request = 1'b0;
      o_bus_rw      = 1'b0;
      o_bus_address = 32'h0;
      o_bus_wdata   = 32'h0;
      o_ibus_ready  = 1'b0;
      o_dbus_ready  = 1'b0;
      o_ibus_rdata  = 32'h0;
      o_dbus_rdata  = 32'h0;
      case (state)
         IDLE: begin
            if (i_ibus_request || i_dbus_request)
               state_nxt = pick_d ? GRANT_D : GRANT_I;
         end
         GRANT_I: begin
            o_bus_request = i_ibus_request;
            o_bus_address = i_ibus_address;
            if (i_bus_ready) begin
               // A real slave answer beats a watchdog expiring on the same cycle.
               o_ibus_ready = 1'b1;
               o_ibus_rdata = i_bus_rdata;
               state_nxt    = IDLE;
            end else if (!i_ibus_request) begin
               state_nxt = IDLE;
            end else if (wd_expired) begin
               o_bus_request = 1'b0;
               o_ibus_ready  = 1'b1;
               set_timeout   = 1'b1;
               state_nxt     = IDLE;
            end
         end
         GRANT_D: begin
            o_bus_request = i_dbus_request;
            o_bus_address = i_dbus_address;
            o_bus_rw      = i_dbus_rw;
            o_bus_wdata   = i_dbus_wdata;
            if (i_bus_ready) begin
               o_dbus_ready = 1'b1;
               o_dbus_rdata = i_bus_rdata;
               state_nxt    = IDLE;
            end else if (!i_dbus_request) begin
               state_nxt = IDLE;
            end else if (wd_expired) begin
               o_bus_request = 1'b0;
               o_dbus_ready  = 1'b1;
               set_timeout   = 1'b1;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Watchdog counts grant cycles without ready; held at zero in IDLE so each grant starts at k=0.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)
         wd_cnt <= '0;
      else if (state == IDLE)
         wd_cnt <= '0;
      else if (!i_bus_ready)
         wd_cnt <= wd_cnt + CW'(1);
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)
         o_timeout <= 1'b0;
      else if (set_timeout)
         o_timeout <= 1'b1;
   end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter with TIMEOUT=16.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// Tie-break expectations follow CPU_BUS_ARBITER_ROUND_ROBIN_EN when defined.
module tb_cpu_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ibus_request, ibus_ready;
   logic [31:0] ibus_address, ibus_rdata;
   logic        dbus_rw, dbus_request, dbus_ready;
   logic [31:0] dbus_address, dbus_rdata, dbus_wdata;
   logic        bus_rw, bus_request, bus_ready;
   logic [31:0] bus_address, bus_rdata, bus_wdata;
   logic        timeout;

   int n_tests = 0;
   int n_fail  = 0;

   cpu_bus_arbiter #(.TIMEOUT(16)) dut (
      .i_clock        (clk),
      .i_reset        (rst_n),
      .i_ibus_request (ibus_request),
      .o_ibus_ready   (ibus_ready),
      .i_ibus_address (ibus_address),
      .o_ibus_rdata   (ibus_rdata),
      .i_dbus_rw      (dbus_rw),
      .i_dbus_request (dbus_request),
      .o_dbus_ready   (dbus_ready),
      .i_dbus_address (dbus_address),
      .o_dbus_rdata   (dbus_rdata),
      .i_dbus_wdata   (dbus_wdata),
      .o_bus_rw       (bus_rw),
      .o_bus_request  (bus_request),
      .i_bus_ready    (bus_ready),
      .o_bus_address  (bus_address),
      .i_bus_rdata    (bus_rdata),
      .o_bus_wdata    (bus_wdata),
      .o_timeout      (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic        rr_i_second;   // 1 = the re-requesting ibus is expected to win the second tie
   logic [31:0] exp_addr;

   initial begin
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
      rr_i_second = 1'b1;
`else
      rr_i_second = 1'b0;
`endif
      rst_n = 1'b0;
      ibus_request = 0; ibus_address = 0;
      dbus_request = 0; dbus_rw = 0; dbus_address = 0; dbus_wdata = 0;
      bus_ready = 0; bus_rdata = 0;

      // Reset state
      #1;
      chk("rst_bus_request", {31'b0, bus_request}, 32'd0);
      chk("rst_timeout", {31'b0, timeout}, 32'd0);
      chk("rst_address", bus_address, 32'd0);
      tick(); tick();
      rst_n = 1'b1;

      // Test 1: ibus read, ready at c3
      tick();                                      // c0
      ibus_request = 1; ibus_address = 32'h100; #1;
      chk("t1_c0_req", {31'b0, bus_request}, 32'd0);
      tick(); #1;                                  // c1
      chk("t1_c1_req", {31'b0, bus_request}, 32'd1);
      chk("t1_c1_addr", bus_address, 32'h100);
      chk("t1_c1_rw", {31'b0, bus_rw}, 32'd0);
      tick(); #1;                                  // c2
      chk("t1_c2_ready", {31'b0, ibus_ready}, 32'd0);
      tick();                                      // c3
      bus_ready = 1; bus_rdata = 32'hDEADBEEF; #1;
      chk("t1_c3_req", {31'b0, bus_request}, 32'd1);
      chk("t1_c3_iready", {31'b0, ibus_ready}, 32'd1);
      chk("t1_c3_irdata", ibus_rdata, 32'hDEADBEEF);
      chk("t1_c3_dready", {31'b0, dbus_ready}, 32'd0);
      tick();                                      // c4
      bus_ready = 0; bus_rdata = 0; ibus_request = 0; #1;
      chk("t1_c4_req", {31'b0, bus_request}, 32'd0);

      // Test 2: contention, then dbus re-requests immediately while ibus still waits
      tick();                                      // c0
      ibus_request = 1; ibus_address = 32'h200;
      dbus_request = 1; dbus_address = 32'h300; dbus_rw = 0; #1;
      tick(); #1;                                  // c1
      chk("t2_first_addr", bus_address, 32'h300);
      tick();                                      // c2
      bus_ready = 1; bus_rdata = 32'h11; #1;
      chk("t2_first_dready", {31'b0, dbus_ready}, 32'd1);
      chk("t2_first_drdata", dbus_rdata, 32'h11);
      chk("t2_first_iready", {31'b0, ibus_ready}, 32'd0);
      tick();                                      // c3: idle gap
      bus_ready = 0; dbus_address = 32'h304; #1;
      chk("t2_gap_req", {31'b0, bus_request}, 32'd0);
      tick(); #1;                                  // c4
      exp_addr = rr_i_second ? 32'h200 : 32'h304;
      chk("t2_second_addr", bus_address, exp_addr);
      tick();                                      // c5
      bus_ready = 1; bus_rdata = 32'h22; #1;
      chk("t2_second_iready", {31'b0, ibus_ready}, {31'b0, rr_i_second});
      chk("t2_second_dready", {31'b0, dbus_ready}, {31'b0, ~rr_i_second});
      tick();                                      // c6
      bus_ready = 0;
      if (rr_i_second) ibus_request = 0; else dbus_request = 0;
      #1;
      chk("t2_gap2_req", {31'b0, bus_request}, 32'd0);
      tick(); #1;                                  // c7
      exp_addr = rr_i_second ? 32'h304 : 32'h200;
      chk("t2_third_addr", bus_address, exp_addr);
      tick();                                      // c8
      bus_ready = 1; bus_rdata = 32'h33; #1;
      chk("t2_third_iready", {31'b0, ibus_ready}, {31'b0, ~rr_i_second});
      chk("t2_third_dready", {31'b0, dbus_ready}, {31'b0, rr_i_second});
      tick();                                      // c9
      bus_ready = 0; ibus_request = 0; dbus_request = 0; #1;

      // Test 3: dbus write
      tick();
      dbus_request = 1; dbus_rw = 1; dbus_address = 32'h20000010; dbus_wdata = 32'h12345678; #1;
      tick(); #1;
      chk("t3_rw", {31'b0, bus_rw}, 32'd1);
      chk("t3_wdata", bus_wdata, 32'h12345678);
      chk("t3_addr", bus_address, 32'h20000010);
      tick();
      bus_ready = 1; #1;
      chk("t3_dready", {31'b0, dbus_ready}, 32'd1);
      chk("t3_iready", {31'b0, ibus_ready}, 32'd0);
      tick();
      bus_ready = 0; dbus_request = 0; dbus_rw = 0; dbus_wdata = 0; #1;
      chk("t3_after_rw", {31'b0, bus_rw}, 32'd0);

      // Test 4: watchdog, grant at c1 (k=0), synthesized response at c17 (k=16)
      tick();                                      // c0
      dbus_request = 1; dbus_address = 32'h40; bus_rdata = 32'hAAAA5555; #1;
      for (int c = 1; c <= 16; c++) begin
         tick(); #1;
         if (dbus_ready !== 1'b0) chk("t4_early_dready", {31'b0, dbus_ready}, 32'd0);
      end
      chk("t4_c16_req", {31'b0, bus_request}, 32'd1);
      tick(); #1;                                  // c17
      chk("t4_c17_dready", {31'b0, dbus_ready}, 32'd1);
      chk("t4_c17_drdata", dbus_rdata, 32'd0);
      chk("t4_c17_req", {31'b0, bus_request}, 32'd0);
      tick();                                      // c18
      dbus_request = 0; bus_rdata = 0; #1;
      chk("t4_timeout_set", {31'b0, timeout}, 32'd1);
      tick();
      ibus_request = 1; ibus_address = 32'h500; #1;
      tick(); tick();
      bus_ready = 1; bus_rdata = 32'hCAFEF00D; #1;
      chk("t4_iread_ready", {31'b0, ibus_ready}, 32'd1);
      chk("t4_iread_rdata", ibus_rdata, 32'hCAFEF00D);
      tick();
      bus_ready = 0; bus_rdata = 0; ibus_request = 0; #1;
      chk("t4_timeout_sticky", {31'b0, timeout}, 32'd1);

      // Test 6: abort at k=2, then stray ready in IDLE
      tick();                                      // c0
      dbus_request = 1; dbus_address = 32'h60; #1;
      tick(); tick(); #1;                          // c2, k=1
      chk("t6_k1_req", {31'b0, bus_request}, 32'd1);
      tick();                                      // c3, k=2
      dbus_request = 0; #1;
      chk("t6_abort_req", {31'b0, bus_request}, 32'd0);
      chk("t6_abort_dready", {31'b0, dbus_ready}, 32'd0);
      tick();                                      // IDLE
      bus_ready = 1; bus_rdata = 32'h77; #1;
      chk("t6_stray_dready", {31'b0, dbus_ready}, 32'd0);
      chk("t6_stray_iready", {31'b0, ibus_ready}, 32'd0);
      tick();
      bus_ready = 0; bus_rdata = 0; #1;
      chk("t6_idle_req", {31'b0, bus_request}, 32'd0);

      // Test 5: reset in the middle of a dbus grant
      tick();
      dbus_request = 1; dbus_address = 32'h80; #1;
      tick(); #1;
      chk("t5_granted_req", {31'b0, bus_request}, 32'd1);
      #1;
      rst_n = 0; bus_ready = 1; #1;
      chk("t5_rst_req", {31'b0, bus_request}, 32'd0);
      chk("t5_rst_dready", {31'b0, dbus_ready}, 32'd0);
      chk("t5_rst_addr", bus_address, 32'd0);
      chk("t5_rst_timeout", {31'b0, timeout}, 32'd0);
      tick();
      dbus_request = 0; bus_ready = 0; #1;
      rst_n = 1;
      tick();
      bus_ready = 1; #1;
      chk("t5_post_req", {31'b0, bus_request}, 32'd0);
      chk("t5_post_dready", {31'b0, dbus_ready}, 32'd0);
      chk("t5_post_timeout", {31'b0, timeout}, 32'd0);
      tick();
      bus_ready = 0; #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
